// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read bus between the fetch stage (master) and a
// 1-cycle-latency registered instruction memory (slave).
//
// Signals:
//   imem_read    master->slave  read strobe (memRead)
//   imem_write   master->slave  write strobe (memWrite), always 0 from fetch
//   imem_address master->slave  byte address
//   imem_wdata   master->slave  write data (mem_in), always 0 from fetch
//   imem_rdata   slave->master  read data (mem_out), valid the cycle after
//                               imem_read
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              imem_read;
  logic              imem_write;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_wdata;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_read, imem_write, imem_address, imem_wdata,
    input  imem_rdata
  );

  modport slave (
    input  imem_read, imem_write, imem_address, imem_wdata,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Holds the PC, issues one word read per cycle to a
// 1-cycle-latency instruction memory, buffers returned words with their PC in
// a DEPTH-entry FIFO and presents the head to decode. A redirect from execute
// flushes every buffered and in-flight word and restarts fetch at the target.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   imem            fetch_unit_if.master, instruction-memory read bus
//   stall           decode cannot take the head instruction this cycle
//   redirect_valid  restart fetch at redirect_pc (low 2 bits forced to 0)
//   redirect_pc     restart address
//   if_valid        head instruction valid
//   if_instr        head instruction word
//   if_pc           head instruction address
//   halted          self-jump seen (only with FETCH_HALT_EN)
//
// Optional feature macro: FETCH_HALT_EN. When defined, a captured self-jump
// (JAL with zero immediate) stops further fetching until reset. When
// undefined, halted is tied to 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              halted_q;

  logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];
  logic [DATA_W-1:0] fifo_instr_q [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  assign if_valid = (count_q != '0);
  assign pop      = if_valid && !stall && !redirect_valid;

  // Words that arrive after a halt was recorded are past the self-jump and
  // must never reach decode, so capture is also blocked while halted.
  assign push     = inflight_q && !redirect_valid && !halted_q;

  // Credit check: buffered words plus the one in flight, less the one leaving
  // this cycle, must leave room for the word about to be requested.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue     = !rst && !halted_q && !redirect_valid
                     && (occupancy < (CNT_W+1)'(DEPTH));

  assign imem.imem_read    = issue;
  assign imem.imem_write   = 1'b0;
  assign imem.imem_address = pc_q;
  assign imem.imem_wdata   = '0;

  // Outputs read as zero while empty so a freshly reset stage shows 0/0.
  assign if_instr = if_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q]    : '0;
  assign halted   = halted_q;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_W'(4);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: the FIFO storage has no reset; count_q alone decides which entries
  // are live, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem.imem_rdata;
    end
  end

`ifdef FETCH_HALT_EN
  logic self_jump;

  // JAL (opcode 1101111) with an all-zero immediate jumps to itself.
  assign self_jump = (imem.imem_rdata[6:0] == 7'b1101111)
                     && (imem.imem_rdata[DATA_W-1:12] == '0);

  always_ff @(posedge clk) begin
    if (rst)                    halted_q <= 1'b0;
    else if (push && self_jump) halted_q <= 1'b1;
  end
`else
  assign halted_q = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit against a registered 1-cycle instruction memory whose
// word at each address is {25'h0, address} (0x0000006F at 0x10 when the halt
// scenario is armed). A queue-based reference model predicts outputs every
// cycle; directed phases add literal expectations on the delivered PCs.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0), .DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  bit halt_word_en = 1'b0;

  // Reference model state
  ent_t              mq[$];
  bit                m_inflight;
  logic [ADDR_W-1:0] m_ipc;
  logic [ADDR_W-1:0] m_pc;
  bit                m_halted;

  // PCs handed to decode by the DUT (if_valid && !stall && !redirect)
  logic [ADDR_W-1:0] got[$];

  function automatic logic [DATA_W-1:0] mem_word(logic [ADDR_W-1:0] a);
    if (halt_word_en && a == 7'h10) return 32'h0000_006F;
    return {25'h0, a};
  endfunction

  // Registered memory: data appears the cycle after the read, 0 otherwise.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_read ? mem_word(bus.imem_address) : '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cycle %0d: got 0x%h, expected 0x%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare DUT against model, advance model.
  task automatic step(bit r, bit s, bit rv, logic [ADDR_W-1:0] rpc);
    bit e_valid, e_pop, e_read;
    int occ;
    ent_t ent;
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    #1;
    e_valid = (mq.size() != 0);
    e_pop   = e_valid && !s && !rv;
    occ     = mq.size() + int'(m_inflight) - int'(e_pop);
    e_read  = !r && !m_halted && !rv && (occ < DEPTH);
    if (chk_en) begin
      check("if_valid", 32'(if_valid), 32'(e_valid));
      if (e_valid) begin
        check("if_pc",    32'(if_pc), 32'(mq[0].pc));
        check("if_instr", if_instr,   mq[0].instr);
      end
      check("imem_read",    32'(bus.imem_read),    32'(e_read));
      check("imem_address", 32'(bus.imem_address), 32'(m_pc));
      check("imem_write",   32'(bus.imem_write),   32'h0);
      check("imem_wdata",   bus.imem_wdata,        32'h0);
      check("halted",       32'(halted),           32'(m_halted));
    end
    if (!r && if_valid && !s && !rv) got.push_back(if_pc);

    if (r) begin
      mq.delete(); m_inflight = 0; m_ipc = '0; m_pc = '0; m_halted = 0;
    end else if (rv) begin
      mq.delete(); m_inflight = 0; m_pc = rpc & 7'h7C;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_inflight && !m_halted) begin
        ent.pc    = m_ipc;
        ent.instr = mem_word(m_ipc);
        mq.push_back(ent);
`ifdef FETCH_HALT_EN
        if (ent.instr[6:0] == 7'b1101111 && ent.instr[31:12] == 20'h0) m_halted = 1;
`endif
      end
      m_inflight = e_read;
      if (e_read) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 7'd4;
      end
    end
    cyc++;
  endtask

  // Expect the first n delivered PCs to be start, start+4, ... (mod 128).
  task automatic check_run(string name, int start, int n);
    check({name, "_count_ok"}, 32'(got.size() >= n), 32'h1);
    for (int k = 0; k < n && k < got.size(); k++)
      check(name, 32'(got[k]), 32'((start + 4 * k) % 128));
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0);
    got.delete();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset: first edge initialises the DUT; compare from then on.
    step(1, 0, 0, '0);
    chk_en = 1'b1;
    check("rst_read", 32'(bus.imem_read), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, '0);
      check("rst_read",  32'(bus.imem_read), 32'h0);
      check("rst_valid", 32'(if_valid),      32'h0);
    end
    check("rst_instr", if_instr,      32'h0);
    check("rst_pc",    32'(if_pc),    32'h0);
    got.delete();

    // Release and stream
    step(0, 0, 0, '0);
    check("first_read", 32'(bus.imem_read),    32'h1);
    check("first_addr", 32'(bus.imem_address), 32'h0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("first_valid", 32'(if_valid), 32'h1);
    check("first_pc",    32'(if_pc),    32'h0);
    check("first_instr", if_instr,      32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0);
    check_run("stream", 0, 4);

    // Stall for 6 cycles from the first valid cycle
    do_reset(2);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, '0);
      check("stall_head", 32'(if_pc), 32'h0);
      if (i == 2) check("stall_read_drop", 32'(bus.imem_read), 32'h0);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0);
    check_run("stall_seq", 0, 6);

    // Redirect with 2 buffered + 1 in flight, stall also high
    do_reset(2);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    step(0, 1, 1, 7'h40);
    step(0, 0, 0, '0);
    check("redir_flush", 32'(if_valid), 32'h0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("redir_valid", 32'(if_valid), 32'h1);
    check("redir_pc",    32'(if_pc),    32'h40);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
    check_run("redir_seq", 'h40, 5);

    // Wrap: low bits of the target are ignored
    step(0, 0, 1, 7'h7E);
    got.delete();
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0);
    check_run("wrap_seq", 'h7C, 4);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), ADDR_W'($urandom));

    // Self-jump at 0x10
    halt_word_en = 1'b1;
    do_reset(2);
    for (int i = 0; i < 24; i++) step(0, 0, 0, '0);
`ifdef FETCH_HALT_EN
    check("halt_set",  32'(halted),        32'h1);
    check("halt_read", 32'(bus.imem_read), 32'h0);
    check("halt_last_ok", 32'(got.size() == 5), 32'h1);
    if (got.size() > 0) check("halt_last_pc", 32'(got[$]), 32'h10);
`else
    check("nohalt", 32'(halted), 32'h0);
    check_run("nohalt_seq", 0, 8);
`endif
    halt_word_en = 1'b0;
    do_reset(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
